// File: rtl/mac_pe_pkg.sv
// Shared types, default widths and the accumulate adder for the mac_pe
// processing element. MAC_PE_SAT_EN (see mac_pe.sv) selects saturation.
package mac_pe_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_MULT   = 3;
    localparam int ACC_W_DEF  = ACC_MULT * DATA_W_DEF;

    // Widest accumulator the adder helper handles; ACC_W must stay below this.
    localparam int MAX_W = 64;

    // Output-stationary accumulation states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } os_state_t;

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             ovf;
    } add_res_t;

    // w-bit add with overflow detect and optional clamp. Operands are shifted
    // up so their MSB sits at bit MAX_W-1; carry and sign checks then use
    // fixed bit positions whatever w is. The result is shifted back down.
    function automatic add_res_t acc_add(
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b,
        input int unsigned      w,
        input logic             is_signed,
        input logic             sat_en
    );
        int unsigned      sh;
        logic [MAX_W-1:0] a_al;
        logic [MAX_W-1:0] b_al;
        logic [MAX_W-1:0] s_al;
        logic             carry;
        logic             ov;
        add_res_t         r;
        sh   = MAX_W - w;
        a_al = a << sh;
        b_al = b << sh;
        {carry, s_al} = {1'b0, a_al} + {1'b0, b_al};
        if (is_signed)
            ov = (a_al[MAX_W-1] == b_al[MAX_W-1]) && (s_al[MAX_W-1] != a_al[MAX_W-1]);
        else
            ov = carry;
        if (sat_en && ov) begin
            if (!is_signed)
                s_al = '1;
            else if (a_al[MAX_W-1])
                s_al = {1'b1, {(MAX_W-1){1'b0}}};
            else
                s_al = {1'b0, {(MAX_W-1){1'b1}}};
        end
        r.sum = s_al >> sh;
        r.ovf = ov;
        return r;
    endfunction

endpackage

// File: rtl/mac_pe_mul.sv
// Combinational DATA_W x DATA_W multiplier, signed or unsigned, with the
// 2*DATA_W product sign- or zero-extended to ACC_W.
module mac_pe_mul
    import mac_pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_MULT * DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] w,
    input  logic              signed_mode,
    output logic [ACC_W-1:0]  product
);

    logic [2*DATA_W-1:0] prod_raw;
    logic                ext;

    // Full-width product; operands extended per signedness first.
    always_comb begin
        if (signed_mode)
            prod_raw = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{w[DATA_W-1]}}, w});
        else
            prod_raw = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, w};
    end

    // Extend the product up to accumulator width.
    always_comb begin
        ext     = signed_mode & prod_raw[2*DATA_W-1];
        product = {ACC_W{ext}};
        product[2*DATA_W-1:0] = prod_raw;
    end

endmodule

// File: rtl/mac_pe.sv
// Systolic-array MAC processing element supporting weight-stationary and
// output-stationary dataflows with a double-buffered weight register.
// Define MAC_PE_SAT_EN to clamp overflowing adds instead of wrapping.
module mac_pe
    import mac_pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_MULT * DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signed_mode,
    input  logic              os_mode,
    input  logic [DATA_W-1:0] w_in,
    input  logic              w_ld,
    input  logic              w_swap,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    input  logic [ACC_W-1:0]  psum_in,
    input  logic              psum_vld_in,
    input  logic              drain,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_vld_out,
    output logic              ovf
);

`ifdef MAC_PE_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    os_state_t                state;
    logic [DATA_W-1:0]        shadow;
    logic [DATA_W-1:0]        w_act;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         product;
    logic                     ws_active;
    logic                     add_used;
    logic [ACC_W-1:0]         add_a;
    add_res_t                 add_r;
    logic [ACC_W-1:0]         acc_sum;
    logic [MAX_W-ACC_W-1:0]   add_hi_unused;

    mac_pe_mul #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mul (
        .a           (a_in),
        .w           (w_act),
        .signed_mode (signed_mode),
        .product     (product)
    );

    // One shared adder: WS adds to psum_in, OS adds to acc while in ACC and
    // to zero when a fresh accumulation starts (IDLE or DRAIN).
    always_comb begin
        ws_active = (state == IDLE) && !os_mode;
        add_used  = a_vld_in && (ws_active || (state == ACC));
        if (ws_active)
            add_a = psum_in;
        else if (state == ACC)
            add_a = acc;
        else
            add_a = '0;
        add_r = acc_add(MAX_W'(add_a), MAX_W'(product), ACC_W, signed_mode, SAT_EN);
        {add_hi_unused, acc_sum} = add_r.sum;
    end

    // Activation forwarding to the neighbouring PE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out     <= '0;
            a_vld_out <= 1'b0;
        end else begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
        end
    end

    // Double-buffered weight: swap reads the pre-load shadow value.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            w_act  <= '0;
        end else begin
            if (w_ld)
                shadow <= w_in;
            if (w_swap)
                w_act <= shadow;
        end
    end

    // Dataflow FSM, accumulator, partial-sum output and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            psum_out     <= '0;
            psum_vld_out <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            psum_out     <= psum_in;
            psum_vld_out <= psum_vld_in;
            if (add_used && add_r.ovf)
                ovf <= 1'b1;
            case (state)
                IDLE: begin
                    if (!os_mode) begin
                        if (a_vld_in) begin
                            psum_out     <= acc_sum;
                            psum_vld_out <= 1'b1;
                        end
                    end else if (a_vld_in) begin
                        acc   <= acc_sum;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (drain) begin
                        psum_out     <= a_vld_in ? acc_sum : acc;
                        psum_vld_out <= 1'b1;
                        acc          <= '0;
                        state        <= DRAIN;
                    end else if (a_vld_in) begin
                        acc <= acc_sum;
                    end
                end
                DRAIN: begin
                    if (a_vld_in) begin
                        acc   <= acc_sum;
                        state <= ACC;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pe.sv
// Self-checking bench for mac_pe: a behavioural model pushes expected
// outputs into a scoreboard queue as each cycle is driven; entries are
// popped and compared one cycle later. Honours MAC_PE_SAT_EN.
module tb_mac_pe;
    import mac_pe_pkg::*;

    localparam int     DW  = 8;
    localparam int     AW  = 24;
    localparam longint MOD = longint'(1) << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          signed_mode;
    logic          os_mode;
    logic [DW-1:0] w_in;
    logic          w_ld;
    logic          w_swap;
    logic [DW-1:0] a_in;
    logic          a_vld_in;
    logic [AW-1:0] psum_in;
    logic          psum_vld_in;
    logic          drain;
    logic [DW-1:0] a_out;
    logic          a_vld_out;
    logic [AW-1:0] psum_out;
    logic          psum_vld_out;
    logic          ovf;

    always #5 clk = ~clk;

    mac_pe #(
        .DATA_W (DW),
        .ACC_W  (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_mode  (signed_mode),
        .os_mode      (os_mode),
        .w_in         (w_in),
        .w_ld         (w_ld),
        .w_swap       (w_swap),
        .a_in         (a_in),
        .a_vld_in     (a_vld_in),
        .psum_in      (psum_in),
        .psum_vld_in  (psum_vld_in),
        .drain        (drain),
        .a_out        (a_out),
        .a_vld_out    (a_vld_out),
        .psum_out     (psum_out),
        .psum_vld_out (psum_vld_out),
        .ovf          (ovf)
    );

    typedef struct {
        logic [DW-1:0] a;
        logic          av;
        logic [AW-1:0] ps;
        logic          pv;
        logic          ov;
    } exp_t;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    string         phase   = "init";

    int            m_st;
    longint        m_acc;
    logic [DW-1:0] m_sh;
    logic [DW-1:0] m_wa;
    logic          m_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    function automatic longint to_s(input longint v, input int w);
        longint x;
        x = v & ((longint'(1) << w) - 1);
        return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
    endfunction

    function automatic longint m_prod(input logic [DW-1:0] a, input logic [DW-1:0] w, input logic sgn);
        longint p;
        p = sgn ? to_s(longint'(a), DW) * to_s(longint'(w), DW) : longint'(a) * longint'(w);
        return p & (MOD - 1);
    endfunction

    function automatic longint m_add(input longint x, input longint y, input logic sgn, output logic ov);
        longint s, hi, lo;
        if (sgn) begin
            s  = to_s(x, AW) + to_s(y, AW);
            hi = (longint'(1) << (AW - 1)) - 1;
            lo = -(longint'(1) << (AW - 1));
        end else begin
            s  = x + y;
            hi = MOD - 1;
            lo = 0;
        end
        ov = (s > hi) || (s < lo);
`ifdef MAC_PE_SAT_EN
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
`endif
        return s & (MOD - 1);
    endfunction

    task automatic model_step();
        exp_t   e;
        longint p, nacc;
        logic   ov;
        if (rst) begin
            m_st = 0; m_acc = 0; m_sh = '0; m_wa = '0; m_ovf = 1'b0;
            e.a = '0; e.av = 1'b0; e.ps = '0; e.pv = 1'b0; e.ov = 1'b0;
        end else begin
            e.a  = a_in;
            e.av = a_vld_in;
            e.ps = psum_in;
            e.pv = psum_vld_in;
            p    = m_prod(a_in, m_wa, signed_mode);
            case (m_st)
                0: begin
                    if (!os_mode) begin
                        if (a_vld_in) begin
                            e.ps  = AW'(m_add(longint'(psum_in), p, signed_mode, ov));
                            e.pv  = 1'b1;
                            m_ovf = m_ovf | ov;
                        end
                    end else if (a_vld_in) begin
                        m_acc = p;
                        m_st  = 1;
                    end
                end
                1: begin
                    nacc = m_acc;
                    if (a_vld_in) begin
                        nacc  = m_add(m_acc, p, signed_mode, ov);
                        m_ovf = m_ovf | ov;
                    end
                    if (drain) begin
                        e.ps  = AW'(nacc);
                        e.pv  = 1'b1;
                        m_acc = 0;
                        m_st  = 2;
                    end else begin
                        m_acc = nacc;
                    end
                end
                default: begin
                    if (a_vld_in) begin
                        m_acc = p;
                        m_st  = 1;
                    end else begin
                        m_st = 0;
                    end
                end
            endcase
            if (w_swap) m_wa = m_sh;
            if (w_ld)   m_sh = w_in;
            e.ov = m_ovf;
        end
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check("a_out",        64'(a_out),        64'(e.a));
            check("a_vld_out",    64'(a_vld_out),    64'(e.av));
            check("psum_out",     64'(psum_out),     64'(e.ps));
            check("psum_vld_out", 64'(psum_vld_out), 64'(e.pv));
            check("ovf",          64'(ovf),          64'(e.ov));
        end
    endtask

    task automatic idle_inputs();
        signed_mode = 1'b0; os_mode = 1'b0; w_in = '0; w_ld = 1'b0; w_swap = 1'b0;
        a_in = '0; a_vld_in = 1'b0; psum_in = '0; psum_vld_in = 1'b0; drain = 1'b0;
    endtask

    task automatic load_weight(input logic [DW-1:0] w);
        w_in = w; w_ld = 1'b1; tick();
        w_ld = 1'b0; w_swap = 1'b1; tick();
        w_swap = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        phase = "reset";
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        check("rst_psum",  64'(psum_out),  64'd0);
        check("rst_state", 64'(dut.state), 64'(IDLE));

        phase = "ws_unsigned";
        load_weight(8'd3);
        a_in = 8'd5; a_vld_in = 1'b1; psum_in = 24'd10; tick();
        check("p25", 64'(psum_out), 64'd25);
        check("v25", 64'(psum_vld_out), 64'd1);
        a_vld_in = 1'b0; psum_in = '0; tick();

        phase = "ws_signed";
        load_weight(8'hFE);
        signed_mode = 1'b1; a_in = 8'hFC; a_vld_in = 1'b1; psum_in = '0; tick();
        check("p8", 64'(psum_out), 64'd8);
        signed_mode = 1'b0; tick();
        check("p64008", 64'(psum_out), 64'd64008);
        a_vld_in = 1'b0; tick();

        phase = "dbuf";
        load_weight(8'd2);
        a_in = 8'd1; a_vld_in = 1'b1; w_in = 8'd7; w_ld = 1'b1; tick();
        check("old_w0", 64'(psum_out), 64'd2);
        w_ld = 1'b0; tick();
        w_swap = 1'b1; tick();
        check("old_w1", 64'(psum_out), 64'd2);
        w_swap = 1'b0; tick();
        check("new_w", 64'(psum_out), 64'd7);
        w_in = 8'd9; w_ld = 1'b1; w_swap = 1'b1; tick();
        check("w_act", 64'(dut.w_act), 64'd7);
        check("shadow", 64'(dut.shadow), 64'd9);
        w_ld = 1'b0; w_swap = 1'b0; tick();
        check("after_both", 64'(psum_out), 64'd7);
        a_vld_in = 1'b0; tick();

        phase = "os";
        load_weight(8'd4);
        os_mode = 1'b1; a_in = 8'd1; a_vld_in = 1'b1; tick();
        check("no_pulse", 64'(psum_vld_out), 64'd0);
        os_mode = 1'b0; a_in = 8'd2; psum_in = 24'd123; psum_vld_in = 1'b1; tick();
        check("pass_val", 64'(psum_out), 64'd123);
        os_mode = 1'b1; a_in = 8'd3; drain = 1'b1; psum_in = 24'd777; tick();
        check("drain24", 64'(psum_out), 64'd24);
        check("drain_v", 64'(psum_vld_out), 64'd1);
        drain = 1'b0; a_vld_in = 1'b0; psum_vld_in = 1'b0; psum_in = '0; os_mode = 1'b0; tick();
        check("one_pulse", 64'(psum_vld_out), 64'd0);
        check("idle", 64'(dut.state), 64'(IDLE));
        check("acc0", 64'(dut.acc), 64'd0);
        drain = 1'b1; tick();
        drain = 1'b0;

        phase = "overflow";
        load_weight(8'd1);
        a_in = 8'd1; a_vld_in = 1'b1; psum_in = 24'hFFFFFF; tick();
`ifdef MAC_PE_SAT_EN
        check("sat", 64'(psum_out), 64'hFFFFFF);
`else
        check("wrap", 64'(psum_out), 64'd0);
`endif
        check("ovf_set", 64'(ovf), 64'd1);
        a_vld_in = 1'b0; psum_in = '0; tick();
        check("ovf_sticky", 64'(ovf), 64'd1);
        do_reset();
        check("ovf_clr", 64'(ovf), 64'd0);

        phase = "rst_in_acc";
        load_weight(8'd10);
        os_mode = 1'b1; a_in = 8'd5; a_vld_in = 1'b1; tick();
        check("acc50", 64'(dut.acc), 64'd50);
        a_vld_in = 1'b0; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        check("rst_v", 64'(psum_vld_out), 64'd0);
        drain = 1'b1; tick();
        check("drain_ign", 64'(psum_vld_out), 64'd0);
        drain = 1'b0; os_mode = 1'b0;

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            signed_mode = 1'($urandom_range(0, 1));
            os_mode     = 1'($urandom_range(0, 1));
            w_in        = DW'($urandom());
            w_ld        = ($urandom_range(0, 3) == 0);
            w_swap      = ($urandom_range(0, 5) == 0);
            a_in        = DW'($urandom());
            a_vld_in    = ($urandom_range(0, 3) != 0);
            psum_in     = AW'($urandom());
            psum_vld_in = 1'($urandom_range(0, 1));
            drain       = ($urandom_range(0, 4) == 0);
            tick();
        end
        idle_inputs();
        rst = 1'b0;
        tick();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
